// File: rtl/audio_play_sequencer.sv
// audio_play_sequencer: playlist master for the audio sample buffer.
// Queues segment descriptors and, for each one, programs NUM_SAMPLES,
// SAMPLE_DIV and CTRL over the register bus. It tracks buf_playing to
// detect completion, then repeats, advances or stops.
module audio_play_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          QUEUE_DEPTH = 8,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_num_samples,
  input  logic [31:0] desc_sample_div,
  input  logic [7:0]  desc_repeat,
  input  logic        run,
  input  logic        abort,
  input  logic        err_clr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_wen,
  output logic        m_ren,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic        buf_playing,
  output logic        busy,
  output logic        seg_done,
  output logic [4:0]  queue_count,
  output logic        err
);

  localparam int PW = $clog2(QUEUE_DEPTH);

  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'h0;
  localparam logic [31:0] NUM_ADDR  = BASE_ADDR + 32'h4;
  localparam logic [31:0] DIV_ADDR  = BASE_ADDR + 32'h8;
  localparam logic [31:0] CTRL_PLAY = 32'h5;  // play + load_done
  localparam logic [31:0] CTRL_STOP = 32'h4;  // load_done only

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_NUM, S_LOAD_DIV, S_ARM, S_WAIT_START,
    S_WAIT_END, S_STOP, S_NEXT, S_FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] num;
    logic [31:0] div;
    logic [7:0]  rep;
  } desc_t;

  state_t          state_q, state_d;
  desc_t           mem_q [QUEUE_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [31:0]     m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic            m_wen_q, m_wen_d;
  logic [15:0]     ack_cnt_q, ack_cnt_d;
  logic [32:0]     st_cnt_q, st_cnt_d;
  logic [7:0]      rep_q, rep_d;
  logic            seg_done_q, seg_done_d;
  logic            err_q, err_d;
  logic            abort_pend_q, abort_pend_d;

  logic            push, pop, clr, flushing;
  logic            is_wr, ack_tmo, bus_fail, ack_done, start_to, abort_any;
  logic            entering;
  desc_t           head, head_nx, hsel;

  assign flushing   = (state_q == S_FLUSH) | abort_pend_q | abort;
  assign desc_ready = (count_q < 5'(QUEUE_DEPTH)) & ~flushing;
  assign push       = desc_valid & desc_ready;

  assign head    = mem_q[rd_ptr_q];
  assign head_nx = mem_q[rd_ptr_q + PW'(1)];
  // In NEXT the decision is about the entry behind the one being popped.
  assign hsel    = (state_q == S_NEXT) ? head_nx : head;

  assign is_wr = (state_q == S_LOAD_NUM) | (state_q == S_LOAD_DIV) |
                 (state_q == S_ARM) | (state_q == S_STOP) | (state_q == S_FLUSH);
  // Strobe cycle counts as the first cycle of the ack window.
  assign ack_tmo   = is_wr & ~m_ack & (ack_cnt_q == 16'(ACK_TIMEOUT - 1));
  assign bus_fail  = (is_wr & m_ack & m_err) | ack_tmo;
  assign ack_done  = (is_wr & m_ack) | ack_tmo;
  assign start_to  = (state_q == S_WAIT_START) & ~buf_playing & (st_cnt_q <= 33'd1);
  assign abort_any = abort | abort_pend_q;
  assign entering  = (state_d != state_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (run && count_q != 5'd0 && !abort)
          state_d = (hsel.num == 32'd0) ? S_NEXT : S_LOAD_NUM;
      S_LOAD_NUM:
        if (ack_done) state_d = (bus_fail || abort_any) ? S_FLUSH : S_LOAD_DIV;
      S_LOAD_DIV:
        if (ack_done) state_d = (bus_fail || abort_any) ? S_FLUSH : S_ARM;
      S_ARM:
        if (ack_done) state_d = (bus_fail || abort_any) ? S_FLUSH : S_WAIT_START;
      S_WAIT_START:
        if (abort_any)        state_d = S_FLUSH;
        else if (buf_playing) state_d = S_WAIT_END;
        else if (start_to)    state_d = S_STOP;
      S_WAIT_END:
        if (abort_any)         state_d = S_FLUSH;
        else if (!buf_playing) state_d = S_STOP;
      S_STOP:
        if (ack_done) begin
          if (bus_fail || abort_any) state_d = S_FLUSH;
          else                       state_d = (rep_q != 8'd0) ? S_ARM : S_NEXT;
        end
      S_NEXT:
        if (abort_any) state_d = S_FLUSH;
        else if (run && count_q > 5'd1)
          state_d = (hsel.num == 32'd0) ? S_NEXT : S_LOAD_NUM;
        else state_d = S_IDLE;
      S_FLUSH:
        if (ack_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: bus strobes on state entry, counters, FIFO control
  always_comb begin
    m_wen_d      = 1'b0;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    ack_cnt_d    = ack_cnt_q;
    st_cnt_d     = st_cnt_q;
    rep_d        = rep_q;
    seg_done_d   = 1'b0;
    pop          = 1'b0;
    clr          = 1'b0;

    if (entering) begin
      ack_cnt_d = 16'd0;
      case (state_d)
        S_LOAD_NUM: begin
          m_wen_d   = 1'b1;
          m_addr_d  = NUM_ADDR;
          m_wdata_d = hsel.num;
          rep_d     = (hsel.rep == 8'd0) ? 8'd1 : hsel.rep;
        end
        S_LOAD_DIV: begin
          m_wen_d   = 1'b1;
          m_addr_d  = DIV_ADDR;
          m_wdata_d = hsel.div;
        end
        S_ARM: begin
          m_wen_d   = 1'b1;
          m_addr_d  = CTRL_ADDR;
          m_wdata_d = CTRL_PLAY;
        end
        S_STOP: begin
          m_wen_d   = 1'b1;
          m_addr_d  = CTRL_ADDR;
          m_wdata_d = CTRL_STOP;
          if (rep_q != 8'd0) rep_d = rep_q - 8'd1;
        end
        S_FLUSH: begin
          m_wen_d   = 1'b1;
          m_addr_d  = CTRL_ADDR;
          m_wdata_d = CTRL_STOP;
        end
        default: ;
      endcase
    end else if (is_wr && !m_ack) begin
      ack_cnt_d = ack_cnt_q + 16'd1;
    end

    // Start timeout: one sample period plus slack for the buffer to react
    if (state_d == S_WAIT_START && state_q != S_WAIT_START)
      st_cnt_d = {1'b0, hsel.div} + 33'd16;
    else if (state_q == S_WAIT_START && st_cnt_q != 33'd0)
      st_cnt_d = st_cnt_q - 33'd1;

    // Retire the head; an abort seen in NEXT suppresses the retire
    if (state_q == S_NEXT && state_d != S_FLUSH) begin
      pop        = 1'b1;
      seg_done_d = 1'b1;
    end

    clr = ((state_q == S_IDLE) && abort) || ((state_q == S_FLUSH) && ack_done);

    // A set condition beats err_clr
    if (bus_fail || start_to) err_d = 1'b1;
    else if (err_clr)         err_d = 1'b0;
    else                      err_d = err_q;

    abort_pend_d = abort_pend_q | (abort & (state_q != S_IDLE));
    if (state_d == S_FLUSH || state_d == S_IDLE) abort_pend_d = 1'b0;

    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 5'd0;
    end else begin
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d  = count_q + {4'd0, push} - {4'd0, pop};
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= 5'd0;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      m_wen_q      <= 1'b0;
      ack_cnt_q    <= 16'd0;
      st_cnt_q     <= 33'd0;
      rep_q        <= 8'd0;
      seg_done_q   <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wen_q      <= m_wen_d;
      ack_cnt_q    <= ack_cnt_d;
      st_cnt_q     <= st_cnt_d;
      rep_q        <= rep_d;
      seg_done_q   <= seg_done_d;
      err_q        <= err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  // Descriptor storage, written at the tail on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{num: desc_num_samples, div: desc_sample_div, rep: desc_repeat};
    end
  end

  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wen       = m_wen_q;
  assign m_ren       = 1'b0;
  assign busy        = (state_q != S_IDLE);
  assign seg_done    = seg_done_q;
  assign queue_count = count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_audio_play_sequencer.sv
// Directed bench for audio_play_sequencer with a simple buffer model that
// acks one cycle after each write and plays for NUM_SAMPLES cycles.
module tb_audio_play_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_num_samples, desc_sample_div;
  logic [7:0]  desc_repeat;
  logic        run, abort, err_clr;
  logic [31:0] m_addr, m_wdata;
  logic        m_wen, m_ren, m_ack, m_err;
  logic        buf_playing, busy, seg_done, err;
  logic [4:0]  queue_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  audio_play_sequencer dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_num_samples(desc_num_samples), .desc_sample_div(desc_sample_div),
    .desc_repeat(desc_repeat), .run(run), .abort(abort), .err_clr(err_clr),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen), .m_ren(m_ren),
    .m_ack(m_ack), .m_err(m_err), .buf_playing(buf_playing),
    .busy(busy), .seg_done(seg_done), .queue_count(queue_count), .err(err)
  );

  // Buffer model
  logic        ack_en, play_en;
  logic        b_ack, b_playing;
  logic [31:0] b_num, b_cnt;
  assign m_ack       = b_ack;
  assign m_err       = 1'b0;
  assign buf_playing = b_playing;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_ack <= 1'b0; b_playing <= 1'b0; b_num <= 32'd0; b_cnt <= 32'd0;
    end else begin
      b_ack <= ack_en & m_wen;
      if (b_playing) begin
        if (b_cnt <= 32'd1) b_playing <= 1'b0;
        b_cnt <= b_cnt - 32'd1;
      end
      if (m_wen && ack_en) begin
        if (m_addr == 32'h4) b_num <= m_wdata;
        if (m_addr == 32'h0) begin
          if (m_wdata[0] && play_en) begin
            b_playing <= 1'b1;
            b_cnt     <= b_num;
          end else if (!m_wdata[0]) begin
            b_playing <= 1'b0;
          end
        end
      end
    end
  end

  // Bus write log and retire counter
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int seg_cnt = 0;
  always @(negedge clk) begin
    if (m_wen === 1'b1) begin
      log_a.push_back(m_addr);
      log_d.push_back(m_wdata);
    end
    if (seg_done === 1'b1) seg_cnt++;
  end

  function automatic logic [31:0] geta(input int i);
    if (i < log_a.size()) return log_a[i];
    return 'x;
  endfunction

  function automatic logic [31:0] getd(input int i);
    if (i < log_d.size()) return log_d[i];
    return 'x;
  endfunction

  function automatic int count_w(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    for (int i = 0; i < log_a.size(); i++)
      if (log_a[i] === a && log_d[i] === d) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] n, input logic [31:0] d, input logic [7:0] r);
    desc_valid = 1'b1; desc_num_samples = n; desc_sample_div = d; desc_repeat = r;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_d.delete();
    seg_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(tag, {31'd0, (c < maxc)}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; desc_valid = 1'b0; desc_num_samples = 32'd0; desc_sample_div = 32'd0;
    desc_repeat = 8'd0; run = 1'b0; abort = 1'b0; err_clr = 1'b0;
    ack_en = 1'b1; play_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_desc_ready", {31'd0, desc_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_wen", {31'd0, m_wen}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_qc", {27'd0, queue_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_seg_done", {31'd0, seg_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();

    // Single segment, with cycle-exact strobe timing
    push(32'd4, 32'd10, 8'd1);
    chk("one_qc_after_push", {27'd0, queue_count}, 32'd1);
    chk("one_idle_run0", {31'd0, busy}, 32'd0);
    run = 1'b1;
    @(negedge clk);
    chk("one_num_strobe", {31'd0, m_wen}, 32'd1);
    chk("one_num_addr", m_addr, 32'h4);
    chk("one_num_data", m_wdata, 32'd4);
    @(negedge clk);
    chk("one_ack_gap", {31'd0, m_wen}, 32'd0);
    @(negedge clk);
    chk("one_div_strobe", {31'd0, m_wen}, 32'd1);
    chk("one_div_addr", m_addr, 32'h8);
    wait_idle("one_idle_timeout", 200);
    chk("one_nwrites", log_a.size(), 32'd4);
    chk("one_w2_addr", geta(1), 32'h8);
    chk("one_w2_data", getd(1), 32'd10);
    chk("one_w3_addr", geta(2), 32'h0);
    chk("one_w3_data", getd(2), 32'h5);
    chk("one_w4_addr", geta(3), 32'h0);
    chk("one_w4_data", getd(3), 32'h4);
    chk("one_seg_done", seg_cnt, 32'd1);
    chk("one_qc_end", {27'd0, queue_count}, 32'd0);
    chk("one_busy_end", {31'd0, busy}, 32'd0);
    clear_logs();

    // Repeat count of three
    push(32'd3, 32'd5, 8'd3);
    @(negedge clk);
    wait_idle("rep_idle_timeout", 300);
    chk("rep_nwrites", log_a.size(), 32'd8);
    chk("rep_arm_cnt", count_w(32'h0, 32'h5), 32'd3);
    chk("rep_stop_cnt", count_w(32'h0, 32'h4), 32'd3);
    chk("rep_num_cnt", count_w(32'h4, 32'd3), 32'd1);
    chk("rep_div_cnt", count_w(32'h8, 32'd5), 32'd1);
    chk("rep_seg_done", seg_cnt, 32'd1);
    run = 1'b0;
    clear_logs();

    // Fill the queue with zero-length entries, overflow, then push+pop
    for (int i = 0; i < 8; i++) push(32'd0, 32'd1, 8'd1);
    chk("full_qc", {27'd0, queue_count}, 32'd8);
    chk("full_ready", {31'd0, desc_ready}, 32'd0);
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    chk("full_9th_ignored", {27'd0, queue_count}, 32'd8);
    run = 1'b1;
    @(negedge clk);
    chk("full_first_next_qc", {27'd0, queue_count}, 32'd8);
    @(negedge clk);
    chk("full_after_pop_qc", {27'd0, queue_count}, 32'd7);
    chk("full_seg_done_pulse", {31'd0, seg_done}, 32'd1);
    desc_valid = 1'b1; desc_num_samples = 32'd0;
    @(negedge clk);
    desc_valid = 1'b0;
    chk("pushpop_qc_same", {27'd0, queue_count}, 32'd7);
    wait_idle("full_idle_timeout", 100);
    chk("full_qc_end", {27'd0, queue_count}, 32'd0);
    chk("full_seg_cnt", seg_cnt, 32'd9);
    chk("full_no_writes", log_a.size(), 32'd0);
    run = 1'b0;
    clear_logs();

    // Zero-length descriptor between two normal ones
    push(32'd3, 32'd4, 8'd1);
    push(32'd0, 32'd7, 8'd1);
    push(32'd3, 32'd4, 8'd1);
    run = 1'b1;
    @(negedge clk);
    wait_idle("zero_idle_timeout", 300);
    chk("zero_nwrites", log_a.size(), 32'd8);
    chk("zero_w5_addr", geta(4), 32'h4);
    chk("zero_w5_data", getd(4), 32'd3);
    chk("zero_w6_data", getd(5), 32'd4);
    chk("zero_seg_cnt", seg_cnt, 32'd3);
    chk("zero_qc_end", {27'd0, queue_count}, 32'd0);
    run = 1'b0;
    clear_logs();

    // Abort during WAIT_END with three queued
    for (int i = 0; i < 3; i++) push(32'd60, 32'd2, 8'd1);
    run = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    clear_logs();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run = 1'b0;
    wait_idle("abort_idle_timeout", 50);
    chk("abort_nwrites", log_a.size(), 32'd1);
    chk("abort_w_addr", geta(0), 32'h0);
    chk("abort_w_data", getd(0), 32'h4);
    chk("abort_qc", {27'd0, queue_count}, 32'd0);
    chk("abort_no_seg_done", seg_cnt, 32'd0);
    clear_logs();

    // Bus never acks: ack timeout, flush attempt, flush timeout
    ack_en = 1'b0;
    push(32'd4, 32'd10, 8'd1);
    run = 1'b1;
    @(negedge clk);
    chk("noack_strobe", {31'd0, m_wen}, 32'd1);
    repeat (15) @(negedge clk);
    chk("noack_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("noack_err_set", {31'd0, err}, 32'd1);
    chk("noack_flush_strobe", {31'd0, m_wen}, 32'd1);
    chk("noack_flush_data", m_wdata, 32'h4);
    run = 1'b0;
    wait_idle("noack_idle_timeout", 40);
    chk("noack_qc", {27'd0, queue_count}, 32'd0);
    chk("noack_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("noack_err_clr", {31'd0, err}, 32'd0);
    ack_en = 1'b1;
    clear_logs();

    // buf_playing never rises: start timeout after div+16 cycles
    play_en = 1'b0;
    push(32'd4, 32'd10, 8'd1);
    run = 1'b1;
    @(negedge clk);
    repeat (31) @(negedge clk);
    chk("start_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("start_err_set", {31'd0, err}, 32'd1);
    chk("start_stop_strobe", {31'd0, m_wen}, 32'd1);
    chk("start_stop_data", m_wdata, 32'h4);
    run = 1'b0;
    wait_idle("start_idle_timeout", 40);
    chk("start_seg_cnt", seg_cnt, 32'd1);
    chk("start_qc", {27'd0, queue_count}, 32'd0);
    chk("start_err_sticky", {31'd0, err}, 32'd1);
    play_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_play_sequencer.md
# audio_play_sequencer

Playlist controller that drives the audio sample buffer's system-bus register interface as a bus master. It holds a small queue of segment descriptors (sample count, rate divider, repeat count) and, for each one, programs the buffer's NUM_SAMPLES, SAMPLE_DIV and CTRL registers. It watches the buffer's `playing` status to detect segment completion, then stops, repeats or advances. It sits between the PS-side control logic and the audio buffer, so the CPU enqueues segments instead of polling playback.

## Interface
- `BASE_ADDR`, 32'h0: buffer register base; CTRL at +0x0, NUM_SAMPLES at +0x4, SAMPLE_DIV at +0x8.
- `QUEUE_DEPTH`, 8: descriptor FIFO entries (power of two, 2..16).
- `ACK_TIMEOUT`, 16: cycles to wait for `m_ack` after a write strobe.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `desc_valid` in 1: descriptor push request.
- `desc_ready` out 1: FIFO can accept a descriptor.
- `desc_num_samples` in 32: sample count for the segment.
- `desc_sample_div` in 32: clock cycles per sample.
- `desc_repeat` in 8: play count; 0 is treated as 1.
- `run` in 1: level; permits starting new segments.
- `abort` in 1: one-cycle pulse; stops playback and flushes the queue.
- `err_clr` in 1: one-cycle pulse; clears `err`.
- `m_addr` out 32: bus address.
- `m_wdata` out 32: bus write data.
- `m_wen` out 1: bus write strobe, one cycle per write.
- `m_ren` out 1: tied to 0.
- `m_ack` in 1: bus acknowledge.
- `m_err` in 1: bus error, sampled together with `m_ack`.
- `buf_playing` in 1: buffer playing status.
- `busy` out 1: high whenever the state is not IDLE.
- `seg_done` out 1: one-cycle pulse when a descriptor is retired.
- `queue_count` out 5: number of FIFO entries currently held.
- `err` out 1: sticky error flag.

## Operation
- FIFO behaviour:
  - Push occurs on `desc_valid & desc_ready`.
  - `desc_ready = (queue_count < QUEUE_DEPTH) & ~flushing`.
  - A push and a pop in the same cycle leave the count unchanged.
  - Writes to a full FIFO are impossible because `desc_ready` is 0.
- States: IDLE, LOAD_NUM, LOAD_DIV, ARM, WAIT_START, WAIT_END, STOP, NEXT, FLUSH.
- IDLE: when `run=1` and `queue_count>0`:
  - go to LOAD_NUM;
  - exception: if the head descriptor has `num_samples==0`, go to NEXT directly with no bus traffic.
- Write states (LOAD_NUM, LOAD_DIV, ARM, STOP):
  - issue one write, then wait for `m_ack`;
  - LOAD_NUM writes the head `num_samples` to +0x4;
  - LOAD_DIV writes the head `sample_div` to +0x8;
  - ARM writes 32'h5 (play + load_done) to CTRL;
  - STOP writes 32'h4 (load_done only) to CTRL.
- Transitions on ack:
  - LOAD_NUM→LOAD_DIV→ARM→WAIT_START.
  - STOP→ARM if the remaining repeat count is greater than 0 (it was decremented on entry to STOP); otherwise STOP→NEXT.
- Repeat counter: loaded from `desc_repeat` (0 becomes 1) on IDLE→LOAD_NUM.
- WAIT_START:
  - wait for `buf_playing=1`, then go to WAIT_END;
  - a start timeout counter loads with `sample_div+16`; on expiry set `err` and go to STOP.
- WAIT_END: on `buf_playing=0`, go to STOP.
- NEXT:
  - pop the FIFO, pulse `seg_done`;
  - if `run=1` and the FIFO is non-empty after the pop, go to LOAD_NUM (or the zero-length skip);
  - otherwise go to IDLE.
- Dropping `run` mid-segment: the current segment, including its repeats, completes; no new descriptor starts.
- `abort` in any non-IDLE state:
  - if a write is outstanding, wait for its ack or timeout first;
  - then go to FLUSH, which writes CTRL=32'h4 once, clears the FIFO and returns to IDLE;
  - `seg_done` is not pulsed.
  - `abort` in IDLE clears the FIFO only.
- Bus errors: `m_err` with `m_ack`, or an ack timeout, sets `err` and takes the FLUSH path. A timeout inside FLUSH itself goes straight to IDLE.
- `err` priority: a set condition wins over `err_clr` in the same cycle.

## Timing
- Reset values:
  - all outputs 0 except `desc_ready=1`;
  - FIFO empty; state IDLE; counters 0.
- Registered outputs: `m_addr`, `m_wdata`, `m_wen`.
  - `m_wen` is high exactly one cycle, in the cycle after the edge that enters a write state.
  - The next `m_wen` comes no earlier than the cycle after `m_ack` is sampled high.
- Bus timing against the buffer (which acks one cycle after `wen`): each write takes 2 cycles.
  - Edge E0 samples `run` and non-empty in IDLE.
  - NUM write strobe in cycle E0+1, DIV in E0+3, ARM in E0+5.
  - WAIT_START is entered at E0+6.
- `seg_done`: asserts the cycle after entering NEXT; `queue_count` decrements at the same edge.
- `busy`: drops the cycle the state returns to IDLE.
- Ack timeout: counted from the strobe cycle; the `ACK_TIMEOUT`-th cycle without ack is the timeout.
- Reset mid-operation: the FSM returns to IDLE immediately and no stop write is issued. The buffer is reset by the system reset.

## Test plan
- Push one descriptor (num=4, div=10, repeat=1), `run=1`, buffer model:
  - required: writes (+0x4,4), (+0x8,10), (+0x0,5), then (+0x0,4) after `playing` falls;
  - required: one `seg_done`; `queue_count` 1→0; `busy` low afterwards.
- repeat=3:
  - required: the ARM/STOP write pair occurs exactly 3 times; NUM/DIV are written once; one `seg_done`.
- Fill with 8 descriptors:
  - required: `desc_ready=0`, and a 9th `desc_valid` is ignored;
  - then, with push and pop in the same cycle: `queue_count` stays constant.
- Zero-length descriptor between two normal ones:
  - required: no bus writes for it; three `seg_done` pulses in total.
- `abort` during WAIT_END with 3 queued:
  - required: a single CTRL=4 write; `queue_count=0`; no `seg_done`; IDLE.
- Bus model never acks:
  - required: `err=1` after 16 cycles, then a FLUSH attempt, then IDLE;
  - `err_clr` clears `err`;
  - `buf_playing` never rising: `err` is set after `div+16` cycles.
